// File: rtl/bcd_seg_scanner_if.sv
// ============================================================================
// Module      : bcd_seg_scanner_if
// Description : BCD input and 7-segment drive bundle for bcd_seg_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_seg_scanner_if;
    logic        en;
    logic [11:0] bcd;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame_done;

    modport master (
        output en, bcd, blank_lz,
        input  seg, an, frame_done
    );

    modport slave (
        input  en, bcd, blank_lz,
        output seg, an, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/bcd_seg_scanner.sv
// ============================================================================
// Module      : bcd_seg_scanner
// Description : Frame-snapshotted 3-digit multiplexed 7-segment driver with
//               inter-digit blanking gap and optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seg_scanner #(
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bcd_seg_scanner_if.slave bus
);

    localparam int c_CNT_MAX  = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int c_CW       = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [c_CW-1:0] c_REF_END = c_CW'(REFRESH_DIV - 1);
    localparam logic [c_CW-1:0] c_GAP_END = c_CW'(c_GAP_LAST);
    localparam logic            c_INV     = (ACTIVE_LOW != 0);
    localparam logic [6:0]      c_SEG_OFF = {7{c_INV}};
    localparam logic [2:0]      c_AN_OFF  = {3{c_INV}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [c_CW-1:0]  r_cnt, w_cnt_nxt;
    logic [11:0]      r_snap, w_snap_nxt;
    logic             r_blz, w_blz_nxt;
    logic             w_fd_nxt;
    logic             w_adv;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic [6:0]       w_seg_hi;
    logic [2:0]       w_an_hi;
    logic [6:0]       r_seg;
    logic [2:0]       r_an;
    logic             r_fd;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h3F;
            4'd1:    f_decode = 7'h06;
            4'd2:    f_decode = 7'h5B;
            4'd3:    f_decode = 7'h4F;
            4'd4:    f_decode = 7'h66;
            4'd5:    f_decode = 7'h6D;
            4'd6:    f_decode = 7'h7D;
            4'd7:    f_decode = 7'h07;
            4'd8:    f_decode = 7'h7F;
            4'd9:    f_decode = 7'h6F;
            default: f_decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_snap_nxt  = r_snap;
        w_blz_nxt   = r_blz;
        w_fd_nxt    = 1'b0;
        w_adv       = 1'b0;
        if (!bus.en) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_ON;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                    w_snap_nxt  = bus.bcd;
                    w_blz_nxt   = bus.blank_lz;
                end
                S_ON: begin
                    if (r_cnt == c_REF_END) begin
                        w_cnt_nxt = '0;
                        if (GAP_CYCLES > 0) w_state_nxt = S_GAP;
                        else                w_adv       = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_END) begin
                        w_cnt_nxt = '0;
                        w_adv     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
            // Leaving the last digit closes the frame and takes a new snapshot.
            if (w_adv) begin
                w_state_nxt = S_ON;
                if (r_idx == 2'd2) begin
                    w_idx_nxt  = 2'd0;
                    w_fd_nxt   = 1'b1;
                    w_snap_nxt = bus.bcd;
                    w_blz_nxt  = bus.blank_lz;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end
        end
    end

    // Outputs are derived from next-state values so they move with the state.
    always_comb begin
        w_nib   = w_snap_nxt[3:0];
        w_blank = 1'b0;
        w_an_hi = 3'b001;
        case (w_idx_nxt)
            2'd1: begin
                w_nib   = w_snap_nxt[7:4];
                w_blank = w_blz_nxt && (w_snap_nxt[11:8] == 4'd0) && (w_snap_nxt[7:4] == 4'd0);
                w_an_hi = 3'b010;
            end
            2'd2: begin
                w_nib   = w_snap_nxt[11:8];
                w_blank = w_blz_nxt && (w_snap_nxt[11:8] == 4'd0);
                w_an_hi = 3'b100;
            end
            default: ;
        endcase
        w_seg_hi = f_decode(w_nib);
        if ((w_state_nxt != S_ON) || w_blank) begin
            w_seg_hi = 7'h00;
            w_an_hi  = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_snap  <= 12'h000;
            r_blz   <= 1'b0;
            r_fd    <= 1'b0;
            r_seg   <= c_SEG_OFF;
            r_an    <= c_AN_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_snap  <= w_snap_nxt;
            r_blz   <= w_blz_nxt;
            r_fd    <= w_fd_nxt;
            r_seg   <= w_seg_hi ^ c_SEG_OFF;
            r_an    <= w_an_hi ^ c_AN_OFF;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_fd;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_scanner.sv
// ============================================================================
// Module      : tb_bcd_seg_scanner
// Description : Directed self-checking bench for bcd_seg_scanner
//               (REFRESH_DIV=4, GAP_CYCLES=1, ACTIVE_LOW=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seg_scanner;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    bcd_seg_scanner_if sif ();

    bcd_seg_scanner #(
        .REFRESH_DIV (4),
        .GAP_CYCLES  (1),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_an"},  12'(sif.an),         12'h007);
        chk({tag, "_seg"}, 12'(sif.seg),        12'h07F);
        chk({tag, "_fd"},  12'(sif.frame_done), 12'h000);
    endtask

    // One 15-cycle frame starting with the cycle after the entry/wrap edge.
    task automatic check_frame(input string tag,
                               input logic [6:0] su, input logic [6:0] st, input logic [6:0] sh,
                               input logic bt, input logic bh, input logic fd0,
                               input logic [11:0] mid_bcd);
        logic [2:0] ean;
        logic [6:0] eseg;
        int         slot;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            slot = k / 5;
            ean  = 3'b111;
            eseg = 7'h7F;
            if ((k % 5) != 4) begin
                case (slot)
                    0: begin ean = 3'b110; eseg = su; end
                    1: if (!bt) begin ean = 3'b101; eseg = st; end
                    default: if (!bh) begin ean = 3'b011; eseg = sh; end
                endcase
            end
            chk($sformatf("%s_an_k%0d", tag, k),  12'(sif.an),  12'(ean));
            chk($sformatf("%s_seg_k%0d", tag, k), 12'(sif.seg), 12'(eseg));
            chk($sformatf("%s_fd_k%0d", tag, k),  12'(sif.frame_done), (k == 0) ? 12'(fd0) : 12'h000);
            if (k == 6) sif.bcd = mid_bcd;
        end
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        rst          = 1'b1;
        sif.en       = 1'b0;
        sif.bcd      = 12'h000;
        sif.blank_lz = 1'b0;

        repeat (2) @(negedge clk);
        chk_off("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_off("idle_en0");

        // Async reset while a digit is lit.
        sif.en  = 1'b1;
        sif.bcd = 12'h123;
        repeat (3) @(negedge clk);
        chk("prerst_an",  12'(sif.an),  12'h006);
        chk("prerst_seg", 12'(sif.seg), 12'h030);
        #2 rst = 1'b1;
        #1 chk_off("async_rst");
        @(negedge clk);
        sif.en = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_off("rel_en0");
        end

        // 123 frame with a mid-frame bcd change, then 456.
        sif.en       = 1'b1;
        sif.bcd      = 12'h123;
        sif.blank_lz = 1'b0;
        check_frame("f1_123", 7'h30, 7'h24, 7'h79, 1'b0, 1'b0, 1'b0, 12'h456);
        check_frame("f2_456", 7'h02, 7'h12, 7'h19, 1'b0, 1'b0, 1'b1, 12'h456);

        sif.bcd      = 12'h007;
        sif.blank_lz = 1'b1;
        check_frame("f3_007lz", 7'h78, 7'h7F, 7'h7F, 1'b1, 1'b1, 1'b1, 12'h007);
        sif.blank_lz = 1'b0;
        check_frame("f4_007", 7'h78, 7'h40, 7'h40, 1'b0, 1'b0, 1'b1, 12'h007);

        sif.bcd      = 12'h0A5;
        sif.blank_lz = 1'b1;
        check_frame("f5_0a5", 7'h12, 7'h3F, 7'h7F, 1'b0, 1'b1, 1'b1, 12'h0A5);

        // Drop enable during the tens slot, then restart with a new snapshot.
        sif.bcd      = 12'h321;
        sif.blank_lz = 1'b0;
        @(negedge clk);
        chk("f6_fd",     12'(sif.frame_done), 12'h001);
        chk("f6_u_an",   12'(sif.an),         12'h006);
        chk("f6_u_seg",  12'(sif.seg),        12'h079);
        repeat (5) @(negedge clk);
        chk("f6_t_an",   12'(sif.an),         12'h005);
        chk("f6_t_seg",  12'(sif.seg),        12'h024);
        sif.en  = 1'b0;
        sif.bcd = 12'h987;
        @(negedge clk);
        chk_off("en_drop");
        sif.en = 1'b1;
        check_frame("f7_987", 7'h78, 7'h00, 7'h10, 1'b0, 1'b0, 1'b0, 12'h987);
        @(negedge clk);
        chk("f7_wrap_fd",  12'(sif.frame_done), 12'h001);
        chk("f7_wrap_an",  12'(sif.an),         12'h006);
        chk("f7_wrap_seg", 12'(sif.seg),        12'h078);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
